// File: rtl/divsqrt_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : divsqrt_ctrl_pkg
// Brief    : Shared types and derived constants for the divide/sqrt iteration
//            controller (state encoding, digits per cycle, iteration count).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package divsqrt_ctrl_pkg;

  // Widest supported format and recurrence configuration
  localparam int NF             = 52;
  localparam int NE             = 11;
  localparam int LOGR           = 2;
  localparam int DIVCOPIES      = 2;
  localparam int LOGNORMSHIFTSZ = 8;

  // Quotient digits retired per cycle and full-precision cycle count
  localparam int D     = LOGR * DIVCOPIES;
  localparam int ITERS = (NF + 2 + D - 1) / D;
  localparam int CNTW  = $clog2(ITERS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } divsqrt_state_t;

endpackage : divsqrt_ctrl_pkg

`default_nettype wire

// File: rtl/divsqrt_iter_calc.sv
//------------------------------------------------------------------------------
// Module   : divsqrt_iter_calc
// Brief    : Maps the unbiased result exponent to the number of iteration
//            cycles needed and the matching normalisation shift correction.
//            Early termination is built only when DIVSQRT_EARLY_TERM_EN is
//            defined; otherwise the full count and a zero shift are returned.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module divsqrt_iter_calc
  import divsqrt_ctrl_pkg::*;
(
  input  logic [NE+1:0]             divue_i,
  output logic [CNTW-1:0]           iter_n_o,
  output logic [LOGNORMSHIFTSZ-1:0] shift_o
);

`ifdef DIVSQRT_EARLY_TERM_EN
  // Significant result bits when the result lands in the subnormal range
  logic signed [NE+2:0] bits_w;
  logic        [NE+2:0] quot_w;

  // Subnormal results need only enough cycles to produce the surviving bits
  always_comb begin
    bits_w   = $signed((NE+3)'(NF + 2)) + $signed({divue_i[NE+1], divue_i});
    quot_w   = '0;
    iter_n_o = CNTW'(ITERS);
    if (!divue_i[NE+1] && (divue_i != '0)) begin
      iter_n_o = CNTW'(ITERS);
    end else if (bits_w[NE+2] || (bits_w == '0)) begin
      // Nothing survives rounding position: one cycle still primes the datapath
      iter_n_o = CNTW'(1);
    end else begin
      quot_w   = ($unsigned(bits_w) + (NE+3)'(D - 1)) / (NE+3)'(D);
      iter_n_o = CNTW'(quot_w);
    end
  end

  // Each skipped cycle leaves D digits unshifted
  assign shift_o = LOGNORMSHIFTSZ'((ITERS - int'(iter_n_o)) * D);
`else
  logic unused_divue_w;

  assign iter_n_o       = CNTW'(ITERS);
  assign shift_o        = '0;
  assign unused_divue_w = ^divue_i;
`endif

endmodule : divsqrt_iter_calc

`default_nettype wire

// File: rtl/divsqrt_iter_ctrl.sv
//------------------------------------------------------------------------------
// Module   : divsqrt_iter_ctrl
// Brief    : Sequencing FSM for the FP divide/sqrt digit-recurrence datapath.
//            Accepts an op in IDLE, runs N iteration cycles, then holds the
//            done indication until acknowledged. Kill aborts from any state.
//            Optional feature macro: DIVSQRT_EARLY_TERM_EN (subnormal early
//            termination with normalisation shift correction).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module divsqrt_iter_ctrl
  import divsqrt_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      DivStart,
  input  logic [NE+1:0]             DivUe,
  input  logic                      Kill,
  input  logic                      DivAck,
  output logic                      DivReady,
  output logic                      FirstIter,
  output logic                      IterEn,
  output logic [CNTW-1:0]           IterCnt,
  output logic                      DivDone,
  output logic [LOGNORMSHIFTSZ-1:0] EarlyTermShiftAmt
);

  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  divsqrt_state_t            state_q, state_d;
  logic [CNTW-1:0]           cnt_q, cnt_d;
  logic [LOGNORMSHIFTSZ-1:0] shift_q, shift_d;
  logic                      first_q, first_d;

  logic [CNTW-1:0]           calc_n_w;
  logic [LOGNORMSHIFTSZ-1:0] calc_shift_w;

  divsqrt_iter_calc u_iter_calc (
    .divue_i  (DivUe),
    .iter_n_o (calc_n_w),
    .shift_o  (calc_shift_w)
  );

  // State, remaining-cycle counter, shift amount and first-cycle flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      first_q <= first_d;
    end
  end

  // Next-state and output decode; Kill outranks every other transition
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    first_d  = 1'b0;
    DivReady = 1'b0;
    IterEn   = 1'b0;
    DivDone  = 1'b0;
    case (state_q)
      IDLE: begin
        DivReady = 1'b1;
        if (DivStart && !Kill) begin
          state_d = BUSY;
          cnt_d   = calc_n_w;
          shift_d = calc_shift_w;
          first_d = 1'b1;
        end
      end
      BUSY: begin
        IterEn = 1'b1;
        if (Kill) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        DivDone = 1'b1;
        if (Kill || DivAck) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign FirstIter         = first_q;
  assign IterCnt           = cnt_q;
  assign EarlyTermShiftAmt = shift_q;

endmodule : divsqrt_iter_ctrl

`default_nettype wire

// File: tb/tb_divsqrt_iter_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_divsqrt_iter_ctrl
// Brief    : Directed self-checking bench for divsqrt_iter_ctrl. Expected
//            counts follow DIVSQRT_EARLY_TERM_EN when it is defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_divsqrt_iter_ctrl;
  import divsqrt_ctrl_pkg::*;

  // Hand-computed op lengths / shifts for the directed exponents
`ifdef DIVSQRT_EARLY_TERM_EN
  localparam int N_M20 = 9;
  localparam int S_M20 = 20;
  localparam int N_M60 = 1;
  localparam int S_M60 = 52;
`else
  localparam int N_M20 = 14;
  localparam int S_M20 = 0;
  localparam int N_M60 = 14;
  localparam int S_M60 = 0;
`endif
  localparam int N_FULL = 14;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      DivStart;
  logic [NE+1:0]             DivUe;
  logic                      Kill;
  logic                      DivAck;
  logic                      DivReady;
  logic                      FirstIter;
  logic                      IterEn;
  logic [CNTW-1:0]           IterCnt;
  logic                      DivDone;
  logic [LOGNORMSHIFTSZ-1:0] EarlyTermShiftAmt;

  int errors = 0;
  int checks = 0;

  divsqrt_iter_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .DivStart          (DivStart),
    .DivUe             (DivUe),
    .Kill              (Kill),
    .DivAck            (DivAck),
    .DivReady          (DivReady),
    .FirstIter         (FirstIter),
    .IterEn            (IterEn),
    .IterCnt           (IterCnt),
    .DivDone           (DivDone),
    .EarlyTermShiftAmt (EarlyTermShiftAmt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".ready"}, 32'(DivReady), 32'd1);
    check({tag, ".iteren"}, 32'(IterEn), 32'd0);
    check({tag, ".first"}, 32'(FirstIter), 32'd0);
    check({tag, ".done"}, 32'(DivDone), 32'd0);
  endtask

  // Called at a falling edge; returns at the falling edge of cycle 1
  task automatic start_op(input logic [NE+1:0] ue);
    DivUe    = ue;
    DivStart = 1'b1;
    @(negedge clk);
    DivStart = 1'b0;
  endtask

  // Checks BUSY cycles lo..hi of an op of length n, advancing one cycle each
  task automatic busy(input string tag, input int n, input int shift, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      check({tag, ".iteren"}, 32'(IterEn), 32'd1);
      check({tag, ".first"}, 32'(FirstIter), (i == 1) ? 32'd1 : 32'd0);
      check({tag, ".cnt"}, 32'(IterCnt), 32'(n - i + 1));
      check({tag, ".shift"}, 32'(EarlyTermShiftAmt), 32'(shift));
      check({tag, ".done"}, 32'(DivDone), 32'd0);
      check({tag, ".ready"}, 32'(DivReady), 32'd0);
      @(negedge clk);
    end
  endtask

  // In cycle N+1: result valid, acknowledge, ready in cycle N+2
  task automatic done_ack(input string tag, input int shift);
    check({tag, ".done"}, 32'(DivDone), 32'd1);
    check({tag, ".iteren"}, 32'(IterEn), 32'd0);
    check({tag, ".shift"}, 32'(EarlyTermShiftAmt), 32'(shift));
    check({tag, ".ready_n"}, 32'(DivReady), 32'd0);
    DivAck = 1'b1;
    @(negedge clk);
    DivAck = 1'b0;
    check_idle({tag, ".ack"});
  endtask

  initial begin
    reset    = 1'b1;
    DivStart = 1'b0;
    DivUe    = '0;
    Kill     = 1'b0;
    DivAck   = 1'b0;
    #12;
    check_idle("rst");
    check("rst.cnt", 32'(IterCnt), 32'd0);
    check("rst.shift", 32'(EarlyTermShiftAmt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle("rst_rel");

    // Normal op, positive exponent; DONE held one extra cycle before ack
    start_op(13'sd5);
    busy("pos5", N_FULL, 0, 1, N_FULL);
    check("pos5.hold0", 32'(DivDone), 32'd1);
    @(negedge clk);
    done_ack("pos5", 0);

    // Subnormal exponents and the zero boundary
    start_op(-13'sd20);
    busy("m20", N_M20, S_M20, 1, N_M20);
    done_ack("m20", S_M20);
    start_op(-13'sd60);
    busy("m60", N_M60, S_M60, 1, N_M60);
    done_ack("m60", S_M60);
    start_op(13'sd0);
    busy("zero", N_FULL, 0, 1, N_FULL);
    done_ack("zero", 0);

    // Kill in BUSY cycle 5, then a new op accepted straight away
    start_op(13'sd5);
    busy("k5", N_FULL, 0, 1, 4);
    check("k5.cnt5", 32'(IterCnt), 32'(N_FULL - 4));
    Kill = 1'b1;
    @(negedge clk);
    Kill = 1'b0;
    check_idle("k5.idle");
    check("k5.cnt0", 32'(IterCnt), 32'd0);

    // New op; DivStart re-pulsed in BUSY and in DONE must be ignored
    start_op(13'sd5);
    busy("ign", N_FULL, 0, 1, 3);
    DivUe    = -13'sd60;
    DivStart = 1'b1;
    @(negedge clk);
    DivStart = 1'b0;
    busy("ign", N_FULL, 0, 5, N_FULL);
    DivStart = 1'b1;
    @(negedge clk);
    DivStart = 1'b0;
    check("ign.done_start", 32'(DivDone), 32'd1);
    done_ack("ign", 0);

    // Start together with Kill in IDLE is refused
    DivUe    = 13'sd5;
    DivStart = 1'b1;
    Kill     = 1'b1;
    @(negedge clk);
    DivStart = 1'b0;
    Kill     = 1'b0;
    check_idle("sk");
    check("sk.cnt", 32'(IterCnt), 32'd0);

    // Kill and DivAck together in DONE
    start_op(-13'sd20);
    busy("ka", N_M20, S_M20, 1, N_M20);
    check("ka.done", 32'(DivDone), 32'd1);
    Kill   = 1'b1;
    DivAck = 1'b1;
    @(negedge clk);
    Kill   = 1'b0;
    DivAck = 1'b0;
    check_idle("ka.idle");

    // Kill coincident with the last iteration: no DivDone ever
    start_op(-13'sd20);
    busy("kl", N_M20, S_M20, 1, N_M20 - 1);
    check("kl.cnt1", 32'(IterCnt), 32'd1);
    Kill = 1'b1;
    @(negedge clk);
    Kill = 1'b0;
    check_idle("kl.idle");
    @(negedge clk);
    check("kl.done_later", 32'(DivDone), 32'd0);

    // Asynchronous reset between clock edges in the middle of BUSY
    start_op(-13'sd20);
    busy("ar", N_M20, S_M20, 1, 3);
    #2;
    reset = 1'b1;
    #1;
    check_idle("ar.async");
    check("ar.cnt", 32'(IterCnt), 32'd0);
    check("ar.shift", 32'(EarlyTermShiftAmt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle("ar.after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_divsqrt_iter_ctrl

`default_nettype wire
